// File: rtl/ring_shift_sequencer_if.sv
// Command channel for ring_shift_sequencer: valid/ready handshake carrying
// an opcode, a step count and a load value.
interface ring_shift_sequencer_if #(
    parameter int N  = 69,
    parameter int CW = 7
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic [N-1:0]  cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/ring_shift_sequencer.sv
// ring_shift_sequencer: accepts wait/rotate/load commands and sequences the
// mode/data controls of an external N-bit ring register, tracking the net
// left-rotation offset since the last load.
// Optional build macro RING_SEQ_COUNT_REDUCE_EN: reduces rotate step counts
// modulo N at accept so whole-ring rotations are skipped.
module ring_shift_sequencer #(
    parameter int  N  = 69,
    parameter int  CW = 7,
    localparam int PW = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    ring_shift_sequencer_if.slave   cmd,
    input  logic                    abort,
    output logic [1:0]              mode,
    output logic [N-1:0]            ring_data,
    output logic                    busy,
    output logic                    done,
    output logic [PW-1:0]           rot_pos
);

    localparam logic [1:0] OP_WAIT  = 2'b00;
    localparam logic [1:0] OP_LEFT  = 2'b01;
    localparam logic [1:0] OP_RIGHT = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    op_q;
    logic [CW-1:0] eff_count;
    logic          accept;

    assign accept = (state == IDLE) && cmd.cmd_valid;

    // Effective step count for the offered command.
    always_comb begin
        eff_count = cmd.cmd_count;
`ifdef RING_SEQ_COUNT_REDUCE_EN
        // A wait is a delay, so only rotations fold whole-ring turns away.
        if (cmd.cmd_op != OP_WAIT)
            eff_count = CW'(int'(cmd.cmd_count) % N);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort only matters while stepping.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd.cmd_valid) begin
                    if (cmd.cmd_op == OP_LOAD)   state_nxt = LOAD;
                    else if (eff_count != '0)    state_nxt = STEP;
                    else                         state_nxt = DONE;
                end
            end
            LOAD:    state_nxt = DONE;
            STEP:    if (abort || cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state and registered opcode only.
    always_comb begin
        mode = OP_WAIT;
        case (state)
            LOAD:    mode = OP_LOAD;
            STEP:    mode = op_q;
            default: mode = OP_WAIT;
        endcase
    end

    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign cmd.cmd_ready = (state == IDLE);

    // Command capture and step counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            op_q      <= OP_WAIT;
            ring_data <= '0;
        end else if (accept) begin
            cnt  <= eff_count;
            op_q <= cmd.cmd_op;
            if (cmd.cmd_op == OP_LOAD) ring_data <= cmd.cmd_data;
        end else if (state == STEP) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Rotation offset follows whatever the ring register is told to do.
    always_ff @(posedge clk) begin
        if (rst) begin
            rot_pos <= '0;
        end else begin
            case (mode)
                OP_LOAD:  rot_pos <= '0;
                OP_LEFT:  rot_pos <= (rot_pos == PW'(N - 1)) ? '0 : rot_pos + PW'(1);
                OP_RIGHT: rot_pos <= (rot_pos == '0) ? PW'(N - 1) : rot_pos - PW'(1);
                default:  rot_pos <= rot_pos;
            endcase
        end
    end

endmodule

// File: tb/tb_ring_shift_sequencer.sv
// Self-checking bench for ring_shift_sequencer (N=8, CW=4): directed
// scenarios followed by random commands against a cycle-count model.
module tb_ring_shift_sequencer;
    localparam int N  = 8;
    localparam int CW = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          abort = 1'b0;
    logic [1:0]    mode;
    logic [N-1:0]  ring_data;
    logic          busy;
    logic          done;
    logic [PW-1:0] rot_pos;

    int tests = 0;
    int fails = 0;
    int m_rot = 0;
    logic [7:0] m_ring = 8'h00;

    always #5 clk = ~clk;

    ring_shift_sequencer_if #(.N(N), .CW(CW)) cmd_if ();

    ring_shift_sequencer #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if.slave),
        .abort     (abort),
        .mode      (mode),
        .ring_data (ring_data),
        .busy      (busy),
        .done      (done),
        .rot_pos   (rot_pos)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff_k(input int op, input int cnt);
`ifdef RING_SEQ_COUNT_REDUCE_EN
        if (op == 1 || op == 2) return cnt % N;
`endif
        return cnt;
    endfunction

    // Issue one command and follow it cycle by cycle to the idle cycle after done.
    // abort_at: STEP cycle (1-based) in which abort is held high, 0 for none.
    task automatic run_cmd(input int op, input int cnt, input logic [7:0] data,
                           input int abort_at, input bit abort_on_accept);
        int k;
        int steps;
        chk("ready_before_cmd", cmd_if.cmd_ready, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'(op);
        cmd_if.cmd_count = 4'(cnt);
        cmd_if.cmd_data  = data;
        abort            = abort_on_accept;
        tick();
        cmd_if.cmd_valid = 1'b0;
        abort            = 1'b0;
        k = eff_k(op, cnt);
        if (op == 3) begin
            chk("load_mode", mode, 3);
            chk("load_busy", busy, 1);
            chk("load_ring_data", ring_data, data);
            chk("load_done_low", done, 0);
            tick();
            m_ring = data;
            m_rot  = 0;
        end else begin
            steps = (abort_at > 0 && abort_at < k) ? abort_at : k;
            for (int i = 1; i <= steps; i++) begin
                chk("step_mode", mode, op);
                chk("step_done_low", done, 0);
                chk("step_ready_low", cmd_if.cmd_ready, 0);
                if (i == abort_at) abort = 1'b1;
                tick();
                abort = 1'b0;
            end
            if (op == 1) m_rot = (m_rot + steps) % N;
            if (op == 2) m_rot = (((m_rot - steps) % N) + N) % N;
        end
        chk("done_pulse", done, 1);
        chk("done_mode", mode, 0);
        chk("done_ready_low", cmd_if.cmd_ready, 0);
        chk("done_busy", busy, 1);
        tick();
        chk("idle_ready", cmd_if.cmd_ready, 1);
        chk("idle_done_low", done, 0);
        chk("idle_busy_low", busy, 0);
        chk("idle_mode", mode, 0);
        chk("idle_rot_pos", rot_pos, m_rot);
        chk("idle_ring_data", ring_data, m_ring);
    endtask

    initial begin
        int op, cnt, ab;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op    = 2'b00;
        cmd_if.cmd_count = '0;
        cmd_if.cmd_data  = '0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mode", mode, 0);
        chk("rst_ring_data", ring_data, 0);
        chk("rst_rot_pos", rot_pos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", cmd_if.cmd_ready, 1);

        // Load A5
        run_cmd(3, 0, 8'hA5, 0, 1'b0);
        chk("load_a5_rot", rot_pos, 0);
        // Rotate left 3
        run_cmd(1, 3, 8'h00, 0, 1'b0);
        chk("left3_rot", rot_pos, 3);
        // Right wrap from 0
        run_cmd(3, 0, 8'h5A, 0, 1'b0);
        run_cmd(2, 2, 8'h00, 0, 1'b0);
        chk("right_wrap_rot", rot_pos, 6);
        // Zero count
        run_cmd(1, 0, 8'h00, 0, 1'b0);
        chk("zero_count_rot", rot_pos, 6);
        // Wait op leaves offset alone
        run_cmd(0, 4, 8'h00, 0, 1'b0);
        chk("wait_rot", rot_pos, 6);
        // Abort in 2nd STEP cycle
        run_cmd(3, 0, 8'h11, 0, 1'b0);
        run_cmd(1, 10, 8'h00, 2, 1'b0);
        chk("abort_rot", rot_pos, 2);
        // Abort coinciding with accept is ignored
        run_cmd(2, 3, 8'h00, 0, 1'b1);
        chk("abort_on_accept_rot", rot_pos, 7);
        // Count reduction / full count
        run_cmd(3, 0, 8'h22, 0, 1'b0);
        run_cmd(1, 9, 8'h00, 0, 1'b0);
        chk("count9_rot", rot_pos, 1);

        // Reset mid-command
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_op    = 2'b01;
        cmd_if.cmd_count = 4'd5;
        tick();
        cmd_if.cmd_valid = 1'b0;
        tick();
        chk("pre_rst_mode", mode, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mode", mode, 0);
        chk("midrst_rot_pos", rot_pos, 0);
        chk("midrst_done", done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_if.cmd_ready, 1);
        chk("midrst_ring_data", ring_data, 0);
        tick();
        chk("midrst_no_done_later", done, 0);
        m_rot  = 0;
        m_ring = 8'h00;

        // Random commands
        for (int t = 0; t < 60; t++) begin
            op  = int'($urandom_range(0, 3));
            cnt = int'($urandom_range(0, 15));
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
            run_cmd(op, cnt, 8'($urandom), ab, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running, expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ring_shift_sequencer.md
RING_SHIFT_SEQUENCER -- requirements
Module: ring_shift_sequencer

Interface
REQ-001 Parameter N, default 69: width of the driven ring register, N >= 2.
REQ-002 Parameter CW, default 7: width of the command step count.
REQ-003 Parameter PW = $clog2(N), derived: width of rot_pos.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 cmd_valid  input  1  command offered.
REQ-007 cmd_ready  output  1  sequencer can accept a command.
REQ-008 cmd_op  input  2  operation: 00 wait, 01 rotate left, 10 rotate right, 11 load.
REQ-009 cmd_count  input  CW  step count for ops 00/01/10; ignored for 11.
REQ-010 cmd_data  input  N  load value for op 11.
REQ-011 abort  input  1  terminate a running wait/rotate command.
REQ-012 mode  output  2  ring register mode: 00 hold, 01 left, 10 right, 11 load.
REQ-013 ring_data  output  N  ring register load data.
REQ-014 busy  output  1  command in progress (state != IDLE).
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 rot_pos  output  PW  net left-rotation offset since last load, modulo N.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD, STEP and DONE; mode, ring_data, busy, done and cmd_ready are registered or decoded from state only, with no combinational path from any input.
REQ-018 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a clk edge with cmd_valid && cmd_ready.
REQ-019 Accept with op 11 -> LOAD: ring_data <= cmd_data, mode = 11 for exactly one cycle, then DONE.
REQ-020 Accept with op 00/01/10 and effective count K > 0 -> STEP: mode = cmd_op for exactly K consecutive cycles, then DONE.
REQ-021 Accept with op 00/01/10 and effective count 0 -> DONE next cycle; mode stays 00 throughout.
REQ-022 The step counter SHALL load K on accept and decrement once per STEP cycle; STEP exits when the counter reaches 1.
REQ-023 DONE SHALL last one cycle with done = 1, mode = 00, cmd_ready = 0; it is followed by IDLE.
REQ-024 mode SHALL be 00 in IDLE and DONE.
REQ-025 ring_data SHALL hold its last loaded value until the next op 11.
REQ-026 abort sampled high in STEP SHALL force DONE next cycle, with mode = 00 from that cycle.
REQ-027 abort SHALL be ignored in IDLE, LOAD and DONE, including when it coincides with a command accept.
REQ-028 rot_pos updates per cycle:
  - set to 0 on each LOAD cycle;
  - +1 mod N on each mode-01 cycle (N-1 wraps to 0);
  - -1 mod N on each mode-10 cycle (0 wraps to N-1);
  - unchanged otherwise.
REQ-029 The effective count K SHALL equal cmd_count unless modified per REQ-032.

Reset
REQ-030 rst high on an edge SHALL force state IDLE, mode = 00, ring_data = 0, rot_pos = 0, busy = 0, done = 0, step counter = 0.
REQ-031 rst mid-command SHALL discard the command with no done pulse; cmd_ready = 1 on the first cycle after rst deasserts.

Configuration
REQ-032 Macro RING_SEQ_COUNT_REDUCE_EN:
  - defined: for ops 01/10, K = cmd_count mod N, computed at accept (a count of N yields K = 0);
  - undefined: K = cmd_count for all ops and no modulo logic is built;
  - op 00 is never reduced.

Verification
REQ-033 The bench SHALL use N = 8, CW = 4 and cover these scenarios:
  - Load: accept op 11, cmd_data = 8'hA5 -> one cycle mode = 11 with ring_data = 8'hA5, then done pulse, then rot_pos = 0 and cmd_ready = 1.
  - Rotate left: accept op 01, count 3 -> mode = 01 for 3 cycles, done on the 4th cycle, rot_pos = 3.
  - Right wrap: from rot_pos = 0, accept op 10, count 2 -> rot_pos = 6.
  - Zero count: accept op 01, count 0 -> no non-00 mode cycle, done on the next cycle.
  - Abort: accept op 01, count 10, abort in the 2nd STEP cycle -> exactly 2 mode-01 cycles, then done, rot_pos = 2.
  - Reset mid-command: rst in a STEP cycle -> mode = 00, rot_pos = 0, no done pulse.
  - Count reduction: accept op 01, count 9 -> 1 step with RING_SEQ_COUNT_REDUCE_EN defined, 9 steps (rot_pos = 1) without it.
